// File: rtl/fpu_sched_pkg.sv
// Shared definitions for the FPU issue controller: op encodings, flag layout,
// the in-flight tag record and the requester identifier.
package fpu_sched_pkg;

  localparam logic [2:0] FPU_ADD = 3'b000;
  localparam logic [2:0] FPU_SUB = 3'b001;
  localparam logic [2:0] FPU_MUL = 3'b010;
  localparam logic [2:0] FPU_DIV = 3'b011;
  localparam logic [2:0] FPU_I2F = 3'b100;
  localparam logic [2:0] FPU_F2I = 3'b101;

  // Bit positions inside the 9-bit response flag word {illegal, fpu_flags}
  localparam int FLAG_DIV_BY_ZERO = 0;
  localparam int FLAG_ZERO        = 1;
  localparam int FLAG_UNDERFLOW   = 2;
  localparam int FLAG_OVERFLOW    = 3;
  localparam int FLAG_INE         = 4;
  localparam int FLAG_QNAN        = 5;
  localparam int FLAG_SNAN        = 6;
  localparam int FLAG_INF         = 7;
  localparam int ILLEGAL_FLAG     = 8;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
    logic    illegal;
  } tag_t;

  // Encodings 110 and 111 are unused by the FPU core
  function automatic logic is_illegal_op(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/fpu_tag_pipe.sv
// Shift register of in-flight operation tags, one stage per cycle of FPU
// latency plus the operand-register stage in front of the core.
module fpu_tag_pipe
  import fpu_sched_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t i_tag,
  output tag_t o_last,
  output logic o_busy
);

  localparam int DEPTH = LATENCY + 1;

  tag_t r_stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_stage[k] <= '0;
      end
    end else begin
      r_stage[0] <= i_tag;
      for (int k = 1; k < DEPTH; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  always_comb begin
    o_busy = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      o_busy = o_busy | r_stage[k].valid;
    end
  end

  assign o_last = r_stage[DEPTH-1];

endmodule

// File: rtl/fpu_issue_arb.sv
// Round-robin issue controller sharing one pipelined FPU between two
// requesters; results are routed back by a tag pipeline matched to LATENCY.
module fpu_issue_arb
  import fpu_sched_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [5:0]  req_op,
  input  logic [3:0]  req_rmode,
  input  logic [63:0] req_opa,
  input  logic [63:0] req_opb,
  output logic [2:0]  fpu_op,
  output logic [1:0]  fpu_rmode,
  output logic [31:0] fpu_opa,
  output logic [31:0] fpu_opb,
  input  logic [31:0] fpu_out,
  input  logic [7:0]  fpu_flags,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_data,
  output logic [8:0]  rsp_flags,
  output logic        busy
);

  req_id_t     r_ptr;
  logic [2:0]  r_fpuOp;
  logic [1:0]  r_fpuRmode;
  logic [31:0] r_fpuOpa;
  logic [31:0] r_fpuOpb;
  logic [1:0]  r_rspValid;
  logic [31:0] r_rspData;
  logic [8:0]  r_rspFlags;

  logic [1:0]  w_grant;
  logic        w_accept;
  logic        w_sel;
  logic [2:0]  w_selOp;
  logic [1:0]  w_selRmode;
  logic [31:0] w_selOpa;
  logic [31:0] w_selOpb;
  logic        w_illegal;
  tag_t        w_issueTag;
  tag_t        w_lastTag;
  logic        w_busy;

  // A lone requester always wins; the pointer only breaks ties
  always_comb begin
    w_grant = 2'b00;
    unique case (req_valid)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = (r_ptr == REQ1) ? 2'b10 : 2'b01;
      default: w_grant = 2'b00;
    endcase
  end

  assign req_ready  = w_grant;
  assign w_accept   = |w_grant;
  assign w_sel      = w_grant[1];
  assign w_selOp    = w_sel ? req_op[5:3]     : req_op[2:0];
  assign w_selRmode = w_sel ? req_rmode[3:2]  : req_rmode[1:0];
  assign w_selOpa   = w_sel ? req_opa[63:32]  : req_opa[31:0];
  assign w_selOpb   = w_sel ? req_opb[63:32]  : req_opb[31:0];
  assign w_illegal  = is_illegal_op(w_selOp);

  always_comb begin
    w_issueTag         = '0;
    w_issueTag.valid   = w_accept;
    w_issueTag.id      = req_id_t'(w_accept & w_sel);
    w_issueTag.illegal = w_accept & w_illegal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= REQ0;
    end else if (w_accept) begin
      r_ptr <= w_sel ? REQ0 : REQ1;
    end
  end

  // Illegal ops never reach the core, so its inputs keep the last legal op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fpuOp    <= '0;
      r_fpuRmode <= '0;
      r_fpuOpa   <= '0;
      r_fpuOpb   <= '0;
    end else if (w_accept && !w_illegal) begin
      r_fpuOp    <= w_selOp;
      r_fpuRmode <= w_selRmode;
      r_fpuOpa   <= w_selOpa;
      r_fpuOpb   <= w_selOpb;
    end
  end

  fpu_tag_pipe #(
    .LATENCY (LATENCY)
  ) u_tagPipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_tag  (w_issueTag),
    .o_last (w_lastTag),
    .o_busy (w_busy)
  );

  // The core result is valid while the last tag is present; capture it here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rspValid <= '0;
      r_rspData  <= '0;
      r_rspFlags <= '0;
    end else if (w_lastTag.valid) begin
      r_rspValid <= (w_lastTag.id == REQ1) ? 2'b10 : 2'b01;
      if (w_lastTag.illegal) begin
        r_rspData  <= QNAN;
        r_rspFlags <= 9'(1 << ILLEGAL_FLAG);
      end else begin
        r_rspData  <= fpu_out;
        r_rspFlags <= {1'b0, fpu_flags};
      end
    end else begin
      r_rspValid <= '0;
      r_rspData  <= '0;
      r_rspFlags <= '0;
    end
  end

  assign fpu_op    = r_fpuOp;
  assign fpu_rmode = r_fpuRmode;
  assign fpu_opa   = r_fpuOpa;
  assign fpu_opb   = r_fpuOpb;
  assign rsp_valid = r_rspValid;
  assign rsp_data  = r_rspData;
  assign rsp_flags = r_rspFlags;
  assign busy      = w_busy;

endmodule

// File: tb/tb_fpu_issue_arb.sv
// Table-driven bench for fpu_issue_arb with a behavioural FPU stand-in and a
// response scoreboard keyed on issue order.
module tb_fpu_issue_arb;
  import fpu_sched_pkg::*;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [5:0]  req_op;
  logic [3:0]  req_rmode;
  logic [63:0] req_opa;
  logic [63:0] req_opb;
  logic [2:0]  fpu_op;
  logic [1:0]  fpu_rmode;
  logic [31:0] fpu_opa;
  logic [31:0] fpu_opb;
  logic [31:0] fpu_out;
  logic [7:0]  fpu_flags;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic [8:0]  rsp_flags;
  logic        busy;

  typedef struct {
    logic [1:0]  valid;
    logic [2:0]  op0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [2:0]  op1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [1:0]  expReady;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic [8:0]  flags;
    int          cyc;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  exp_t        expQ[$];
  vec_t        tbl[9];
  logic [2:0]  heldOp;
  logic [1:0]  heldRmode;
  logic [31:0] heldA;
  logic [31:0] heldB;
  logic [39:0] mdl [LAT];

  fpu_issue_arb #(.LATENCY(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_rmode (req_rmode),
    .req_opa   (req_opa),
    .req_opb   (req_opb),
    .fpu_op    (fpu_op),
    .fpu_rmode (fpu_rmode),
    .fpu_opa   (fpu_opa),
    .fpu_opb   (fpu_opb),
    .fpu_out   (fpu_out),
    .fpu_flags (fpu_flags),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_flags (rsp_flags),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Stand-in FPU: exact IEEE results for the cases the plan names, a
  // deterministic scramble elsewhere so routing errors still show
  function automatic logic [39:0] fpuModel(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    logic [7:0]  f;
    r = a ^ {b[15:0], b[31:16]} ^ {29'd0, op};
    f = a[7:0] ^ b[15:8];
    case (op)
      FPU_ADD: if (a == 32'h3F80_0000 && b == 32'h4000_0000) begin r = 32'h4040_0000; f = 8'h00; end
      FPU_SUB: if (a == b) begin r = 32'h0; f = 8'h02; end
      FPU_MUL: if (a == 32'h4000_0000 && b == 32'h4000_0000) begin r = 32'h4080_0000; f = 8'h00; end
      default: ;
    endcase
    return {f, r};
  endfunction

  always @(posedge clk) begin
    mdl[0] <= fpuModel(fpu_op, fpu_opa, fpu_opb);
    for (int k = 1; k < LAT; k++) mdl[k] <= mdl[k-1];
  end

  assign {fpu_flags, fpu_out} = mdl[LAT-1];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic pushLoop();
    exp_t        e;
    logic [2:0]  op;
    logic [39:0] m;
    forever begin
      @(posedge clk);
      cycle++;
      if (!rst_n) begin
        expQ.delete();
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            op    = req_op[i*3 +: 3];
            e.id  = i[0];
            e.cyc = cycle;
            if (op[2] && op[1]) begin
              e.data  = 32'h7FC0_0000;
              e.flags = 9'h100;
            end else begin
              m       = fpuModel(op, req_opa[i*32 +: 32], req_opb[i*32 +: 32]);
              e.data  = m[31:0];
              e.flags = {1'b0, m[39:32]};
            end
            expQ.push_back(e);
          end
        end
      end
    end
  endtask

  task automatic monitorLoop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid != 2'b00) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_rsp: got rsp_valid %b, expected none", rsp_valid);
        end else begin
          e = expQ.pop_front();
          checkOutput("rsp_valid", 32'(rsp_valid), e.id ? 32'd2 : 32'd1);
          checkOutput("rsp_data", rsp_data, e.data);
          checkOutput("rsp_flags", 32'(rsp_flags), 32'(e.flags));
          checkOutput("rsp_latency", 32'(cycle - e.cyc), 32'(LAT + 1));
        end
      end else begin
        checkOutput("idle_rsp_data", rsp_data, 32'h0);
        checkOutput("idle_rsp_flags", 32'(rsp_flags), 32'h0);
      end
    end
  endtask

  // Drives one row, checks the grant, then checks the operand registers
  task automatic applyStimulus(input vec_t v);
    logic [2:0] op;
    @(negedge clk);
    req_valid = v.valid;
    req_op    = {v.op1, v.op0};
    req_opa   = {v.a1, v.a0};
    req_opb   = {v.b1, v.b0};
    #1;
    checkOutput("req_ready", 32'(req_ready), 32'(v.expReady));
    @(posedge clk);
    #1;
    if (v.expReady != 2'b00) begin
      op = v.expReady[1] ? v.op1 : v.op0;
      if (!(op[2] && op[1])) begin
        heldOp    = op;
        heldRmode = v.expReady[1] ? req_rmode[3:2] : req_rmode[1:0];
        heldA     = v.expReady[1] ? v.a1 : v.a0;
        heldB     = v.expReady[1] ? v.b1 : v.b0;
      end
    end
    checkOutput("fpu_op", 32'(fpu_op), 32'(heldOp));
    checkOutput("fpu_rmode", 32'(fpu_rmode), 32'(heldRmode));
    checkOutput("fpu_opa", fpu_opa, heldA);
    checkOutput("fpu_opb", fpu_opb, heldB);
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((busy || expQ.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("[TB] FAIL drain_timeout: got busy %b queue %0d, expected idle", busy, expQ.size());
    end
    repeat (2) @(negedge clk);
  endtask

  function automatic vec_t mk0(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return '{2'b01, op, a, b, 3'd0, 32'd0, 32'd0, 2'b01};
  endfunction

  function automatic vec_t mk1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return '{2'b10, 3'd0, 32'd0, 32'd0, op, a, b, 2'b10};
  endfunction

  function automatic vec_t idleVec();
    return '{2'b00, 3'd0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0, 2'b00};
  endfunction

  initial begin
    tbl[0] = '{2'b11, FPU_MUL, 32'h4000_0000, 32'h4000_0000, FPU_ADD, 32'h1111_1111, 32'h2222_2222, 2'b01};
    tbl[1] = '{2'b11, FPU_DIV, 32'h1234_5678, 32'h9ABC_DEF0, FPU_ADD, 32'h1111_1111, 32'h2222_2222, 2'b10};
    tbl[2] = '{2'b11, FPU_DIV, 32'h1234_5678, 32'h9ABC_DEF0, FPU_I2F, 32'h0000_0007, 32'h0,         2'b01};
    tbl[3] = '{2'b11, FPU_F2I, 32'h4040_0000, 32'h0,         FPU_I2F, 32'h0000_0007, 32'h0,         2'b10};
    tbl[4] = '{2'b01, FPU_F2I, 32'h4040_0000, 32'h0,         3'd0,    32'h0,         32'h0,         2'b01};
    tbl[5] = idleVec();
    tbl[6] = mk1(FPU_SUB, 32'h3F80_0000, 32'h3F80_0000);
    tbl[7] = mk0(FPU_ADD, 32'h3F80_0000, 32'h4000_0000);
    tbl[8] = idleVec();

    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_op    = '0;
    req_rmode = 4'b1001;
    req_opa   = '0;
    req_opb   = '0;
    heldOp    = '0;
    heldRmode = '0;
    heldA     = '0;
    heldB     = '0;
    fork
      pushLoop();
      monitorLoop();
    join_none

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_fpu_opa", fpu_opa, 32'h0);
    checkOutput("reset_fpu_op", 32'(fpu_op), 32'h0);
    req_valid = 2'b11;
    #1;
    checkOutput("reset_ready_comb", 32'(req_ready), 32'h1);
    @(negedge clk);
    checkOutput("reset_no_transfer_busy", 32'(busy), 32'h0);
    req_valid = 2'b00;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) applyStimulus(tbl[i]);
    waitDrain();

    $display("[TB] illegal op between two muls");
    applyStimulus(mk0(FPU_MUL, 32'h4000_0000, 32'h4000_0000));
    applyStimulus(mk0(3'b110, 32'hDEAD_BEEF, 32'hCAFE_F00D));
    checkOutput("illegal_hold_opa", fpu_opa, 32'h4000_0000);
    applyStimulus(mk0(FPU_MUL, 32'h3F80_0000, 32'h4040_0000));
    applyStimulus(mk1(3'b111, 32'h1, 32'h2));
    applyStimulus(idleVec());
    waitDrain();

    $display("[TB] reset with three ops in flight");
    applyStimulus(mk0(FPU_ADD, 32'h0123_4567, 32'h89AB_CDEF));
    applyStimulus(mk1(FPU_MUL, 32'h4000_0000, 32'h4000_0000));
    applyStimulus(mk0(FPU_SUB, 32'h5555_AAAA, 32'h0F0F_0F0F));
    @(negedge clk);
    req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", 32'(busy), 32'h0);
    checkOutput("midreset_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("midreset_rsp_data", rsp_data, 32'h0);
    checkOutput("midreset_fpu_opb", fpu_opb, 32'h0);
    heldOp    = '0;
    heldRmode = '0;
    heldA     = '0;
    heldB     = '0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus('{2'b11, FPU_ADD, 32'h3F80_0000, 32'h4000_0000, FPU_MUL, 32'h7777_0000, 32'h0000_3333, 2'b01});
    applyStimulus('{2'b11, FPU_SUB, 32'h4040_0000, 32'h4040_0000, FPU_MUL, 32'h7777_0000, 32'h0000_3333, 2'b10});
    applyStimulus(mk0(FPU_SUB, 32'h4040_0000, 32'h4040_0000));
    applyStimulus(idleVec());
    waitDrain();

    checkOutput("final_queue_empty", 32'(expQ.size()), 32'h0);
    checkOutput("final_busy", 32'(busy), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
